disp_mux: RTL

- Multiplexed 6-digit 7-segment display driver for the digital clock.
- Consumes the BCD digit pairs produced by the hour, minute and second counters and scans them onto one shared segment bus with per-digit anode enables.
- Supports per-field blinking, used when a field is being set.
- Sits between the timekeeping counters and the board display pins.

---
 rtl/disp_mux.sv | 95 +++++++++
 1 files changed

// File: rtl/disp_mux.sv
// disp_mux: scans six BCD clock digits onto a shared active-low 7-segment bus,
// with a frame-coherent digit snapshot and per-field blinking.
module disp_mux #(
    parameter int DIV_REFRESH = 50000,
    parameter int BLINK_TICKS = 250
) (
    input  logic       disp_clock,
    input  logic       disp_reset,
    input  logic       disp_enable,
    input  logic [3:0] disp_h_Lsd,
    input  logic [1:0] disp_h_Msd,
    input  logic [3:0] disp_m_Lsd,
    input  logic [2:0] disp_m_Msd,
    input  logic [3:0] disp_s_Lsd,
    input  logic [2:0] disp_s_Msd,
    input  logic [2:0] disp_blink_mask,
    output logic [5:0] disp_an,
    output logic [6:0] disp_seg,
    output logic       disp_dp
);
    localparam int PW = $clog2(DIV_REFRESH);
    localparam int BW = $clog2(BLINK_TICKS + 1);
    localparam logic [PW-1:0] PRESC_MAX = PW'(DIV_REFRESH - 1);
    localparam logic [BW-1:0] BLINK_MAX = BW'(BLINK_TICKS - 1);

    logic [PW-1:0]     presc_q, presc_d;
    logic [2:0]        idx_q, idx_d;
    logic [BW-1:0]     blink_q, blink_d;
    logic              phase_q, phase_d;
    logic [5:0][3:0]   snap_q, snap_d;
    logic [5:0]        an_q, an_d;
    logic [6:0]        seg_q, seg_d;
    logic              dp_q, dp_d;
    logic              tick, blank;
    logic [3:0]        digit;

    function automatic logic [6:0] decode(input logic [3:0] v);
        case (v)
            4'd0:    decode = 7'b1000000;
            4'd1:    decode = 7'b1111001;
            4'd2:    decode = 7'b0100100;
            4'd3:    decode = 7'b0110000;
            4'd4:    decode = 7'b0011001;
            4'd5:    decode = 7'b0010010;
            4'd6:    decode = 7'b0000010;
            4'd7:    decode = 7'b1111000;
            4'd8:    decode = 7'b0000000;
            4'd9:    decode = 7'b0010000;
            default: decode = 7'b0111111;
        endcase
    endfunction

    always_comb begin
        tick    = disp_enable && presc_q == PRESC_MAX;
        presc_d = !disp_enable ? presc_q : tick ? '0 : presc_q + PW'(1);
        idx_d   = !tick ? idx_q : idx_q == 3'd5 ? 3'd0 : idx_q + 3'd1;
        blink_d = !tick ? blink_q : blink_q == BLINK_MAX ? '0 : blink_q + BW'(1);
        phase_d = phase_q ^ (tick && blink_q == BLINK_MAX);
        // whole time captured at frame wrap so one frame never mixes two times
        snap_d  = (tick && idx_q == 3'd5) ?
                  {2'b00, disp_h_Msd, disp_h_Lsd, 1'b0, disp_m_Msd, disp_m_Lsd,
                   1'b0, disp_s_Msd, disp_s_Lsd} : snap_q;
        digit   = snap_q[idx_q];
        blank   = phase_q && disp_blink_mask[idx_q[2:1]];
        an_d    = blank ? '1 : ~(6'b000001 << idx_q);
        seg_d   = blank ? '1 : decode(digit);
        dp_d    = blank || !(idx_q == 3'd2 || idx_q == 3'd4);
    end

    always_ff @(posedge disp_clock or negedge disp_reset) begin
        if (!disp_reset) begin
            presc_q <= '0;
            idx_q   <= '0;
            blink_q <= '0;
            phase_q <= 1'b0;
            snap_q  <= '0;
            an_q    <= '1;
            seg_q   <= '1;
            dp_q    <= 1'b1;
        end else begin
            presc_q <= presc_d;
            idx_q   <= idx_d;
            blink_q <= blink_d;
            phase_q <= phase_d;
            snap_q  <= snap_d;
            an_q    <= an_d;
            seg_q   <= seg_d;
            dp_q    <= dp_d;
        end
    end

    assign disp_an  = an_q;
    assign disp_seg = seg_q;
    assign disp_dp  = dp_q;
endmodule
